// File: rtl/rr_select_pkg.sv
// rtl/rr_select_pkg.sv - shared states and constants for the round-robin select generator
package rr_select_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotate-priority encoder choosing the next channel after last
module rr_priority_pick
  import rr_select_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] pick,
  output logic             any_req
);

  // Scan from the farthest rotation back to last+1 so the nearest set bit wins.
  always_comb begin
    pick    = last;
    any_req = 1'b0;
    for (int i = N_CH; i >= 1; i--) begin
      if (req[last + SEL_W'(i)]) begin
        pick    = last + SEL_W'(i);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_select.sv
// rtl/rr_select.sv - round-robin 4:1 mux select generator with dwell limit and settle gap (option: RR_SELECT_STATS_EN)
module rr_select_gen
  import rr_select_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic [N_CH-1:0]  grant,
  output logic             timeout
`ifdef RR_SELECT_STATS_EN
  ,
  output logic [7:0]       timeout_cnt
`endif
);

  state_t             r_state, w_state_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0]   r_last, w_last_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic               r_sel_valid, w_sel_valid_nxt;
  logic [N_CH-1:0]    r_grant, w_grant_nxt;
  logic [SEL_W-1:0]   w_pick;
  logic               w_any_req;
  logic               w_expired;
  logic               w_timeout;

  rr_priority_pick u_pick (
    .req     (req),
    .last    (r_last),
    .pick    (w_pick),
    .any_req (w_any_req)
  );

  assign w_expired = (r_cnt == DWELL_W'(DWELL - 1));

  // State, pointer, dwell counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= SEL_W'(N_CH - 1);
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_grant     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      r_sel       <= w_sel_nxt;
      r_sel_valid <= w_sel_valid_nxt;
      r_grant     <= w_grant_nxt;
    end
  end

  // Arbitrate in IDLE, hold until done/withdraw/expiry, then one settle cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_nxt      = r_last;
    w_sel_nxt       = r_sel;
    w_sel_valid_nxt = 1'b0;
    w_grant_nxt     = '0;
    w_timeout       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt     = HOLD;
          w_sel_nxt       = w_pick;
          w_last_nxt      = w_pick;
          w_cnt_nxt       = '0;
          w_sel_valid_nxt = 1'b1;
          w_grant_nxt     = {{(N_CH-1){1'b0}}, 1'b1} << w_pick;
        end
      end
      HOLD: begin
        if (done || !req[r_sel] || w_expired) begin
          // Timeout is reported only when expiry is the sole reason to end.
          w_timeout   = !done && req[r_sel] && w_expired;
          w_state_nxt = GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt       = r_cnt + DWELL_W'(1);
          w_sel_valid_nxt = 1'b1;
          w_grant_nxt     = r_grant;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign sel       = r_sel;
  assign sel_valid = r_sel_valid;
  assign grant     = r_grant;
  assign timeout   = w_timeout && !reset;

`ifdef RR_SELECT_STATS_EN
  logic [7:0] r_timeout_cnt;

  // Saturating tally of dwell expiries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_cnt <= 8'd0;
    end else if (timeout && (r_timeout_cnt != 8'hFF)) begin
      r_timeout_cnt <= r_timeout_cnt + 8'd1;
    end
  end

  assign timeout_cnt = r_timeout_cnt;
`endif

endmodule
